// File: rtl/bram_pkg.sv
// Shared types and constants for the dual-port BRAM with clear sweep.
package bram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/bram_be_core.sv
// Storage array split into byte lanes: one write port with byte enables and
// one registered read port. WRITE_FIRST picks what a same-address read sees
// when it coincides with a write (old word, or the word with the write merged).
module bram_be_core
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int WRITE_FIRST = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [DATA_WIDTH/BYTE_W-1:0] be,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         re,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]        dout
);

  localparam int NUM_LANES = DATA_WIDTH / BYTE_W;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  logic [NUM_LANES-1:0][BYTE_W-1:0] rd_lane;
  logic                             same_addr;

  assign same_addr = we && (waddr == raddr);

  for (genvar ln = 0; ln < NUM_LANES; ln++) begin : g_lane
    logic [BYTE_W-1:0] mem [DEPTH];
    logic [BYTE_W-1:0] q;
    logic [BYTE_W-1:0] wbyte;

    assign wbyte = din[ln*BYTE_W +: BYTE_W];

    // Byte-lane write; contents are deliberately not reset
    always_ff @(posedge clk) begin
      if (we && be[ln]) mem[waddr] <= wbyte;
    end

    // Read register: updates only on an accepted read, bypasses the write
    // byte on a collision when write-first is selected
    always_ff @(posedge clk) begin
      if (!rst_n)
        q <= '0;
      else if (re)
        q <= ((WRITE_FIRST != 0) && same_addr && be[ln]) ? wbyte : mem[raddr];
    end

    assign rd_lane[ln] = q;
  end

  assign dout = rd_lane;

endmodule

// File: rtl/bram_dp_clr.sv
// Dual-port BRAM (A write, B read) with a full-array clear sweep.
// Optional BRAM_DP_OUTREG_EN adds one output register stage (read latency 2).
module bram_dp_clr
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int WRITE_FIRST = 0,
  parameter int CLR_ON_RST  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         a_we,
  input  logic [DATA_WIDTH/BYTE_W-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]        a_addr,
  input  logic [DATA_WIDTH-1:0]        a_din,
  input  logic                         b_re,
  input  logic [ADDR_WIDTH-1:0]        b_addr,
  output logic [DATA_WIDTH-1:0]        b_dout,
  output logic                         b_valid,
  input  logic                         clr_start,
  output logic                         clr_busy
);

`ifdef BRAM_DP_OUTREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  clr_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  auto_clr;
  logic                  start;
  logic                  port_ok;
  logic                  a_acc, b_acc;

  logic                         core_we, core_re;
  logic [DATA_WIDTH/BYTE_W-1:0] core_be;
  logic [ADDR_WIDTH-1:0]        core_waddr;
  logic [DATA_WIDTH-1:0]        core_din, core_dout;

  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;

  // auto_clr stands in for a clr_start pulse on the first edge after reset
  assign start    = clr_start | auto_clr;
  assign clr_busy = (state == CLEAR);
  // A start request wins over any port traffic in the same cycle
  assign port_ok  = (state == IDLE) && !start;
  assign a_acc    = a_we && port_ok;
  assign b_acc    = b_re && port_ok;

  // Clear FSM and sweep counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      auto_clr <= (CLR_ON_RST != 0);
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      auto_clr <= 1'b0;
    end
  end

  // Next state: one word cleared per cycle, leave after the last address
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == {ADDR_WIDTH{1'b1}}) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write port mux: the sweep owns the port while busy. Writes are held off
  // during reset so an aborted sweep does not clear the word it was on.
  assign core_we    = rst_n && (clr_busy || a_acc);
  assign core_be    = clr_busy ? '1  : a_be;
  assign core_waddr = clr_busy ? cnt : a_addr;
  assign core_din   = clr_busy ? '0  : a_din;
  assign core_re    = rst_n && b_acc;

  bram_be_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (core_we),
    .be    (core_be),
    .waddr (core_waddr),
    .din   (core_din),
    .re    (core_re),
    .raddr (b_addr),
    .dout  (core_dout)
  );

  assign vld_pipe = {vld_q, b_acc};

  // Read-valid shift register, one bit per pipeline stage
  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_pipe[STAGES-1:0];
  end

`ifdef BRAM_DP_OUTREG_EN
  logic [DATA_WIDTH-1:0] dout_q;

  // Output stage captures read data only when it belongs to a read
  always_ff @(posedge clk) begin
    if (!rst_n)         dout_q <= '0;
    else if (vld_pipe[1]) dout_q <= core_dout;
  end

  assign b_dout = dout_q;
`else
  assign b_dout = core_dout;
`endif

  assign b_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_bram_dp_clr.sv
// Scoreboard bench: a read-first/no-autoclear and a write-first/autoclear
// instance share stimulus (64 words); a 16-word instance covers the sweep.
module tb_bram_dp_clr;

`ifdef BRAM_DP_OUTREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared stimulus for the 64-word pair
  logic        rst_n, a_we, b_re, clr_start;
  logic [3:0]  a_be;
  logic [5:0]  a_addr, b_addr;
  logic [31:0] a_din;
  logic [31:0] rf_dout, wf_dout;
  logic        rf_valid, wf_valid, rf_busy, wf_busy;

  // 16-word instance
  logic        c_rst_n, c_we, c_re, c_start;
  logic [3:0]  c_be;
  logic [3:0]  c_addr, c_raddr;
  logic [31:0] c_din, c_dout;
  logic        c_valid, c_busy;

  bram_dp_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WRITE_FIRST(0), .CLR_ON_RST(0)) u_rf (
    .clk(clk), .rst_n(rst_n), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .b_re(b_re), .b_addr(b_addr), .b_dout(rf_dout), .b_valid(rf_valid),
    .clr_start(clr_start), .clr_busy(rf_busy));

  bram_dp_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WRITE_FIRST(1), .CLR_ON_RST(1)) u_wf (
    .clk(clk), .rst_n(rst_n), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .b_re(b_re), .b_addr(b_addr), .b_dout(wf_dout), .b_valid(wf_valid),
    .clr_start(clr_start), .clr_busy(wf_busy));

  bram_dp_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WRITE_FIRST(0), .CLR_ON_RST(0)) u_c (
    .clk(clk), .rst_n(c_rst_n), .a_we(c_we), .a_be(c_be), .a_addr(c_addr), .a_din(c_din),
    .b_re(c_re), .b_addr(c_raddr), .b_dout(c_dout), .b_valid(c_valid),
    .clr_start(c_start), .clr_busy(c_busy));

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t        q_rf[$], q_wf[$], q_c[$];
  logic [31:0] last [3];
  logic [31:0] mdl  [64];
  logic [31:0] mdl_c[16];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Per-instance monitor: pops on b_valid, checks data and latency, flags
  // stray or missing valids, and checks b_dout holds between reads
  task automatic mon(input int id, input logic rn, input logic v, input logic [31:0] d);
    exp_t e;
    bit   have;
    if (!rn) begin
      last[id] = '0;
      return;
    end
    have = 1'b0;
    case (id)
      0: if (q_rf.size() > 0) begin e = q_rf[0]; have = 1'b1; end
      1: if (q_wf.size() > 0) begin e = q_wf[0]; have = 1'b1; end
      default: if (q_c.size() > 0) begin e = q_c[0]; have = 1'b1; end
    endcase
    if (v) begin
      if (!have) chk($sformatf("unexp_valid%0d", id), 32'd1, 32'd0);
      else begin
        chk($sformatf("data%0d", id), d, e.d);
        chk($sformatf("latency%0d", id), cyc, e.due);
        last[id] = d;
      end
    end else begin
      chk($sformatf("hold%0d", id), d, last[id]);
      if (have && e.due < cyc) chk($sformatf("missing_valid%0d", id), 32'd0, 32'd1);
      else have = 1'b0;
    end
    if (have) begin
      case (id)
        0:       void'(q_rf.pop_front());
        1:       void'(q_wf.pop_front());
        default: void'(q_c.pop_front());
      endcase
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst_n,   rf_valid, rf_dout);
    mon(1, rst_n,   wf_valid, wf_dout);
    mon(2, c_rst_n, c_valid,  c_dout);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One cycle on the shared pair; expectations come from the word model
  task automatic op(input bit we, input logic [3:0] be, input logic [5:0] wa,
                    input logic [31:0] wd, input bit re, input logic [5:0] ra);
    a_we = we; a_be = be; a_addr = wa; a_din = wd; b_re = re; b_addr = ra;
    if (re) begin
      q_rf.push_back('{d: mdl[ra], due: cyc + L});
      q_wf.push_back('{d: (we && wa == ra) ? merge(mdl[ra], wd, be) : mdl[ra], due: cyc + L});
    end
    if (we) mdl[wa] = merge(mdl[wa], wd, be);
    tick(1);
    a_we = 1'b0; b_re = 1'b0;
  endtask

  task automatic c_op(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                      input bit re, input logic [3:0] ra);
    c_we = we; c_be = 4'hF; c_addr = wa; c_din = wd; c_re = re; c_raddr = ra;
    if (re) q_c.push_back('{d: mdl_c[ra], due: cyc + L});
    if (we) mdl_c[wa] = wd;
    tick(1);
    c_we = 1'b0; c_re = 1'b0;
  endtask

  task automatic c_preload();
    for (int i = 0; i < 16; i++) c_op(1'b1, 4'(i), 32'hA5A50000 | 32'(i * 17), 1'b0, 4'd0);
  endtask

  task automatic c_readall();
    for (int i = 0; i < 16; i++) c_op(1'b0, 4'd0, 32'd0, 1'b1, 4'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nw;
    rst_n = 1'b0; a_we = 1'b0; a_be = '0; a_addr = '0; a_din = '0;
    b_re = 1'b0; b_addr = '0; clr_start = 1'b0;
    c_rst_n = 1'b0; c_we = 1'b0; c_be = '0; c_addr = '0; c_din = '0;
    c_re = 1'b0; c_raddr = '0; c_start = 1'b0;
    for (int i = 0; i < 64; i++) mdl[i] = 'x;
    tick(3);

    // reset state
    @(negedge clk);
    chk("rst_rf_dout", rf_dout, 32'd0);
    chk("rst_rf_valid", 32'(rf_valid), 32'd0);
    chk("rst_rf_busy", 32'(rf_busy), 32'd0);
    chk("rst_wf_dout", wf_dout, 32'd0);
    chk("rst_wf_valid", 32'(wf_valid), 32'd0);
    chk("rst_wf_busy", 32'(wf_busy), 32'd0);
    chk("rst_c_busy", 32'(c_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; c_rst_n = 1'b1;

    // auto clear after reset release on the write-first instance only
    @(posedge clk); @(negedge clk);
    chk("autoclr_wf_busy", 32'(wf_busy), 32'd1);
    chk("autoclr_rf_busy", 32'(rf_busy), 32'd0);
    n = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!wf_busy) break;
      n++;
    end
    chk("autoclr_len", n, 32'd64);
    @(posedge clk); #1;

    // full write then read back, byte-enable merge
    op(1'b1, 4'hF, 6'h10, 32'hDEADBEEF, 1'b0, 6'h00);
    op(1'b0, 4'h0, 6'h00, 32'h0, 1'b1, 6'h10);
    op(1'b1, 4'b0101, 6'h10, 32'h11223344, 1'b0, 6'h00);
    op(1'b0, 4'h0, 6'h00, 32'h0, 1'b1, 6'h10);
    // collisions: rf returns old word, wf the merged word
    op(1'b1, 4'hF, 6'h20, 32'h9, 1'b0, 6'h00);
    op(1'b1, 4'hF, 6'h20, 32'h5, 1'b1, 6'h20);
    op(1'b0, 4'h0, 6'h00, 32'h0, 1'b1, 6'h20);
    op(1'b1, 4'b0011, 6'h20, 32'h1234CDEF, 1'b1, 6'h20);
    op(1'b0, 4'h0, 6'h00, 32'h0, 1'b1, 6'h20);
    // random traffic over a known-filled window, back-to-back reads
    for (int i = 0; i < 8; i++) op(1'b1, 4'hF, 6'h30 + 6'(i), $urandom, 1'b0, 6'h00);
    for (int i = 0; i < 24; i++)
      op(1'b1, 4'($urandom), 6'h30 + 6'($urandom_range(7)), $urandom,
         1'b1, 6'h30 + 6'($urandom_range(7)));
    tick(4);

    // clr_start wins over same-cycle write/read; both instances sweep
    clr_start = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 6'h10; a_din = 32'hFFFFFFFF;
    b_re = 1'b1; b_addr = 6'h10;
    tick(1);
    clr_start = 1'b0; a_we = 1'b0; b_re = 1'b0;
    for (int i = 0; i < 64; i++) mdl[i] = 32'd0;
    n = 0; nw = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!rf_busy && !wf_busy) break;
      if (rf_busy) n++;
      if (wf_busy) nw++;
      clr_start = (k == 2);
      if (k == 10) begin
        a_we = 1'b1; a_be = 4'hF; a_addr = 6'h00; a_din = 32'hFFFFFFFF;
        b_re = 1'b1; b_addr = 6'h00;
      end else begin
        a_we = 1'b0; b_re = 1'b0;
      end
    end
    clr_start = 1'b0; a_we = 1'b0; b_re = 1'b0;
    chk("clr_len_rf", n, 32'd64);
    chk("clr_len_wf", nw, 32'd64);
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) op(1'b0, 4'h0, 6'h00, 32'h0, 1'b1, 6'(i));
    tick(4);

    // 16-word sweep with dropped traffic mid-sweep
    c_preload();
    c_start = 1'b1;
    tick(1);
    c_start = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!c_busy) break;
      n++;
      c_we = (k == 3); c_re = (k == 3);
      c_be = 4'hF; c_addr = 4'd1; c_din = 32'hFFFFFFFF; c_raddr = 4'd2;
    end
    c_we = 1'b0; c_re = 1'b0;
    chk("c_clr_len", n, 32'd16);
    for (int i = 0; i < 16; i++) mdl_c[i] = 32'd0;
    @(posedge clk); #1;
    c_readall();
    tick(4);

    // reset at sweep cycle 5 aborts; words 5..15 survive
    c_preload();
    c_start = 1'b1;
    tick(1);
    c_start = 1'b0;
    tick(5);
    c_rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("c_abort_busy", 32'(c_busy), 32'd0);
    for (int i = 0; i < 5; i++) mdl_c[i] = 32'd0;
    @(posedge clk); #1;
    c_rst_n = 1'b1;
    tick(1);
    c_readall();
    tick(6);

    chk("drain_rf", q_rf.size(), 32'd0);
    chk("drain_wf", q_wf.size(), 32'd0);
    chk("drain_c", q_c.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_dp_clr.md
BRAM_DP_CLR -- requirements
Module: bram_dp_clr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: address width; depth = 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter WRITE_FIRST, default 0: collision policy (0 = read-first, 1 = write-first).
REQ-004 SHALL have parameter CLR_ON_RST, default 0: 1 = clear sweep starts automatically when reset is released.
REQ-005 SHALL have one clock and a synchronous, active-low reset; clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have rst_n  in  1  synchronous active-low reset.
REQ-007 SHALL have a_we  in  1  port A write enable.
REQ-008 SHALL have a_be  in  DATA_WIDTH/8  port A byte enables; bit i covers din[8i+7:8i].
REQ-009 SHALL have a_addr  in  ADDR_WIDTH  port A address.
REQ-010 SHALL have a_din  in  DATA_WIDTH  port A write data.
REQ-011 SHALL have b_re  in  1  port B read request.
REQ-012 SHALL have b_addr  in  ADDR_WIDTH  port B read address.
REQ-013 SHALL have b_dout  out  DATA_WIDTH  port B read data.
REQ-014 SHALL have b_valid  out  1  b_dout holds data for an accepted read.
REQ-015 SHALL have clr_start  in  1  start-clear pulse.
REQ-016 SHALL have clr_busy  out  1  clear sweep in progress.

Function
REQ-017 SHALL write bytes whose a_be bit is set when a_we=1 and clr_busy=0; other bytes are kept.
REQ-018 SHALL accept a read when b_re=1 and clr_busy=0, capturing b_addr; b_dout/b_valid SHALL appear 1 cycle later (base latency L=1).
REQ-019 SHALL hold b_dout when no read is accepted; b_valid SHALL be 1 only in the cycle(s) matching accepted reads.
REQ-020 SHALL, on a same-cycle A write and B read to the same address, return pre-write data if WRITE_FIRST=0, or merged post-write data (byte-enable applied) if WRITE_FIRST=1.
REQ-021 SHALL implement clear FSM IDLE->CLEAR->IDLE: clr_start=1 in IDLE -> CLEAR with counter=0; CLEAR writes 0 to mem[counter] and increments it every cycle; counter = 2^ADDR_WIDTH-1 -> IDLE.
REQ-022 SHALL assert clr_busy in every CLEAR cycle, so a full sweep takes exactly 2^ADDR_WIDTH cycles.
REQ-023 SHALL ignore clr_start while in CLEAR (no restart).
REQ-024 SHALL ignore A writes and B reads while clr_busy=1; no b_valid is generated for them.
REQ-025 SHALL give clr_start priority over a simultaneous A write or B read in IDLE; that cycle's write/read is dropped.

Reset
REQ-026 SHALL, with rst_n=0 at a clock edge: FSM=IDLE, counter=0, b_valid=0, b_dout=0, clr_busy=0, output pipeline registers cleared.
REQ-027 SHALL NOT reset memory contents.
REQ-028 SHALL, if CLR_ON_RST=1, enter CLEAR on the first edge with rst_n=1 following a reset.
REQ-029 SHALL, on reset mid-sweep, abort to IDLE; the uncleared words keep their old contents.

Configuration
REQ-030 SHALL, with BRAM_DP_OUTREG_EN defined, add an output register stage: L=2 for b_dout and b_valid, the same applying to collision cases.
REQ-031 SHALL, without BRAM_DP_OUTREG_EN, have L=1 and no extra stage.

Structure
REQ-032 SHALL place the clear-FSM state enum (IDLE, CLEAR) and localparam BYTE_W=8 in shared package bram_pkg.
REQ-033 SHALL instantiate the storage array with byte-lane writes as sub-module bram_be_core; FSM, arbitration and pipeline stay in the top level.

Verification
REQ-034 SHALL cover: A write 0xDEADBEEF @0x0010, a_be=4'hF, then B read @0x0010 -> b_valid after L cycles with b_dout=0xDEADBEEF.
REQ-035 SHALL cover: a_be=4'b0101, din=0x11223344 over 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-036 SHALL cover: same-cycle write 0x5 and read @0x20 holding 0x9 -> 0x9 with WRITE_FIRST=0, 0x5 with WRITE_FIRST=1.
REQ-037 SHALL cover: ADDR_WIDTH=4, clr_start -> clr_busy high exactly 16 cycles, all 16 words read 0, A write and B read during the sweep dropped.
REQ-038 SHALL cover: rst_n=0 at sweep cycle 5 -> clr_busy=0 next edge, words 0-4 = 0, words 5-15 unchanged.
REQ-039 SHALL cover: CLR_ON_RST=1 -> clr_busy=1 on the first cycle after reset release; the run is repeated with and without BRAM_DP_OUTREG_EN to check L.
